// File: rtl/display_pkg.sv
// display_pkg: types shared by the rotating-display slice logic.
// Holds the default slice resolution, theta_t and sched_state_t.
package display_pkg;

    localparam int ROT_RES_DEFAULT = 1024;
    localparam int THETA_W = $clog2(ROT_RES_DEFAULT);

    typedef logic [THETA_W-1:0] theta_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_RUN     = 2'd2
    } sched_state_t;

endpackage

// File: rtl/period_meter.sv
// period_meter: index edge detect, rotation period count/latch, timeout.
// Ports: clk_in, rst_in, ir_tripped in; index, period, period_valid, timeout out.
module period_meter
#(
    parameter int PERIOD_W = 24
)
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                ir_tripped,
    output logic                index,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                timeout
);

    logic                ir_q;
    logic                hold;
    logic                seen;
    logic [PERIOD_W-1:0] cnt;

    // hold masks a level that was already high across reset
    // until the sensor has been seen low once.
    assign index   = ir_tripped & ~ir_q & ~hold;
    assign timeout = seen & (&cnt) & ~index;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ir_q         <= 1'b0;
            hold         <= ir_tripped;
            seen         <= 1'b0;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            ir_q <= ir_tripped;
            if (!ir_tripped) begin
                hold <= 1'b0;
            end
            if (index) begin
                cnt  <= PERIOD_W'(1);
                seen <= 1'b1;
                if (seen) begin
                    period       <= cnt;
                    period_valid <= 1'b1;
                end
            end else if (timeout) begin
                seen         <= 1'b0;
                period_valid <= 1'b0;
            end else if (!(&cnt)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/slice_scheduler.sv
// slice_scheduler: locks to the index sensor and issues one slice request
// per 1/ROTATIONAL_RES of a rotation over a valid/ready handshake.
// Ports: clk_in, rst_in, ir_tripped, slice_ready in;
//        slice_valid, dtheta, locked, overrun, overrun_count out.
// Define SLICE_SCHED_OVERRUN_CNT_EN to enable the overrun counter;
// otherwise overrun_count reads 0.
module slice_scheduler
    import display_pkg::*;
#(
    parameter int ROTATIONAL_RES = ROT_RES_DEFAULT,
    parameter int PERIOD_W       = 24
)
(
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              ir_tripped,
    input  logic                              slice_ready,
    output logic                              slice_valid,
    output logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
    output logic                              locked,
    output logic                              overrun,
    output logic [15:0]                       overrun_count
);

    localparam int TW = $clog2(ROTATIONAL_RES);
    localparam logic [TW-1:0] LAST = TW'(ROTATIONAL_RES - 1);

    sched_state_t        state;
    logic                index;
    logic                period_valid;
    logic                timeout;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] interval;
    logic [PERIOD_W-1:0] icnt;
    logic                tick;
    logic                accept;
    logic                pending;

    period_meter #(
        .PERIOD_W (PERIOD_W)
    ) u_meter (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .ir_tripped   (ir_tripped),
        .index        (index),
        .period       (period),
        .period_valid (period_valid),
        .timeout      (timeout)
    );

    // Very fast rotations would give a zero interval; one slice
    // per cycle is the fastest schedule we can issue.
    always_comb begin
        interval = '0;
        if (period_valid) begin
            interval = period >> TW;
            if (interval == '0) begin
                interval = PERIOD_W'(1);
            end
        end
    end

    assign accept  = slice_valid & slice_ready;
    assign pending = slice_valid & ~slice_ready;

    // Index outranks the interval tick; the last slice of a
    // rotation is held until the next index.
    assign tick = (state == ST_RUN) & period_valid & ~index
                & (icnt == interval) & (dtheta != LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= ST_IDLE;
            slice_valid <= 1'b0;
            dtheta      <= '0;
            overrun     <= 1'b0;
            icnt        <= '0;
        end else begin
            overrun <= 1'b0;
            if (icnt < interval) begin
                icnt <= icnt + 1'b1;
            end
            if (timeout) begin
                state       <= ST_IDLE;
                slice_valid <= 1'b0;
            end else if (index) begin
                if (state == ST_IDLE) begin
                    state <= ST_MEASURE;
                end else begin
                    state       <= ST_RUN;
                    dtheta      <= '0;
                    slice_valid <= 1'b1;
                    icnt        <= PERIOD_W'(1);
                    overrun     <= pending;
                end
            end else if (tick) begin
                dtheta      <= dtheta + 1'b1;
                slice_valid <= 1'b1;
                icnt        <= PERIOD_W'(1);
                overrun     <= pending;
            end else if (accept) begin
                slice_valid <= 1'b0;
            end
        end
    end

    assign locked = (state == ST_RUN);

`ifdef SLICE_SCHED_OVERRUN_CNT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            overrun_count <= '0;
        end else if (overrun && overrun_count != 16'hFFFF) begin
            overrun_count <= overrun_count + 16'd1;
        end
    end
`else
    assign overrun_count = 16'h0000;
`endif

endmodule

// File: tb/tb_slice_scheduler.sv
// tb_slice_scheduler: randomized and directed stimulus for slice_scheduler,
// checked every cycle against a timestamp-based reference model.
module tb_slice_scheduler;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        ir_tripped = 1'b0;
    logic        slice_ready = 1'b1;
    logic        slice_valid;
    logic [3:0]  dtheta;
    logic        locked;
    logic        overrun;
    logic [15:0] overrun_count;

    slice_scheduler #(
        .ROTATIONAL_RES (16),
        .PERIOD_W       (16)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .ir_tripped    (ir_tripped),
        .slice_ready   (slice_ready),
        .slice_valid   (slice_valid),
        .dtheta        (dtheta),
        .locked        (locked),
        .overrun       (overrun),
        .overrun_count (overrun_count)
    );

    initial forever #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // stimulus generator state
    bit gen_on = 1'b0;
    int gen_len = 1600;
    int gen_ph = 0;
    bit ir_man = 1'b0;
    int rdy_mode = 0;

    // reference model: timestamps of edges, not register images
    int m_mode = 0;
    bit m_valid = 1'b0;
    int m_dth = 0;
    bit m_ovr = 1'b0;
    int m_cnt = 0;
    bit m_prev = 1'b0;
    bit m_block = 1'b0;
    int cyc = 0;
    int m_last = 0;
    int m_due = 0;
    int m_ivl = 1;

    task automatic model_step();
        bit idx;
        int per;
        if (rst_in) begin
            m_mode = 0;
            m_valid = 1'b0;
            m_dth = 0;
            m_ovr = 1'b0;
            m_cnt = 0;
            m_prev = 1'b0;
            m_block = ir_tripped;
        end else begin
            idx = ir_tripped && !m_prev && !m_block;
            if (!ir_tripped) m_block = 1'b0;
            m_prev = ir_tripped;
`ifdef SLICE_SCHED_OVERRUN_CNT_EN
            if (m_ovr && m_cnt < 65535) m_cnt++;
`endif
            m_ovr = 1'b0;
            if (m_mode != 0 && !idx && (cyc - m_last) >= 65535) begin
                m_mode = 0;
                m_valid = 1'b0;
            end else if (idx) begin
                if (m_mode == 0) begin
                    m_mode = 1;
                end else begin
                    per = cyc - m_last;
                    if (per > 65535) per = 65535;
                    m_ivl = per / 16;
                    if (m_ivl < 1) m_ivl = 1;
                    m_ovr = m_valid && !slice_ready;
                    m_mode = 2;
                    m_dth = 0;
                    m_valid = 1'b1;
                    m_due = cyc + m_ivl;
                end
                m_last = cyc;
            end else if (m_mode == 2 && m_dth < 15 && cyc == m_due) begin
                m_ovr = m_valid && !slice_ready;
                m_dth++;
                m_valid = 1'b1;
                m_due += m_ivl;
            end else if (m_valid && slice_ready) begin
                m_valid = 1'b0;
            end
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            vectors++;
            if (slice_valid !== m_valid || dtheta !== 4'(m_dth)
                || locked !== (m_mode == 2) || overrun !== m_ovr
                || overrun_count !== 16'(m_cnt)) begin
                miscompares++;
                $display("FAIL cycle_cmp t=%0t dut v=%b th=%0d lk=%b ov=%b cnt=%0d required v=%b th=%0d lk=%b ov=%b cnt=%0d",
                         $time, slice_valid, dtheta, locked, overrun, overrun_count,
                         m_valid, m_dth, (m_mode == 2), m_ovr, m_cnt);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // drive inputs at the current negedge, then advance one cycle
    task automatic tick();
        ir_tripped = gen_on ? (gen_ph < 4) : ir_man;
        if (gen_on) gen_ph = (gen_ph + 1 >= gen_len) ? 0 : gen_ph + 1;
        case (rdy_mode)
            0: slice_ready = 1'b1;
            1: slice_ready = ($urandom_range(0, 3) != 0);
            default: slice_ready = 1'b0;
        endcase
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_slice(input int d, input int lim);
        int n = 0;
        while (!(slice_valid && dtheta == 4'(d)) && n < lim) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= lim) begin
            miscompares++;
            $display("FAIL wait_slice: no slice %0d within %0d cycles", d, lim);
        end
    endtask

    task automatic sync_index(input int lim);
        int n = 0;
        do begin
            tick();
            n++;
        end while (gen_ph != 1 && n < lim);
        vectors++;
        if (gen_ph != 1) begin
            miscompares++;
            $display("FAIL sync_index: no index within %0d cycles", lim);
        end
    endtask

    int vc, mx, oc, exp_cnt;

    initial begin
        ticks(3);
        rst_in = 1'b0;
        chk_en = 1'b1;
        chk("rst_valid", 32'(slice_valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_dtheta", 32'(dtheta), 0);
        chk("rst_count", 32'(overrun_count), 0);

        // steady 1600-cycle rotation, always ready
        gen_len = 1600;
        gen_ph = 0;
        gen_on = 1'b1;
        ticks(1600);
        chk("lock_early", 32'(locked), 0);
        tick();
        chk("lock_2nd_idx", 32'(locked), 1);
        chk("lock_slice0", 32'({slice_valid, dtheta}), 32'h10);
        vc = 0; mx = 0; oc = 0;
        for (int i = 0; i < 1600; i++) begin
            if (slice_valid) vc++;
            if (int'(dtheta) > mx) mx = int'(dtheta);
            if (overrun) oc++;
            tick();
        end
        chk("rot_slices", 32'(vc), 16);
        chk("rot_max_theta", 32'(mx), 15);
        chk("rot_overruns", 32'(oc), 0);

        // stall the consumer across one slice interval
        wait_slice(3, 2000);
        rdy_mode = 2;
        oc = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (overrun) oc++;
        end
        chk("stall_overruns", 32'(oc), 1);
        chk("stall_theta", 32'({slice_valid, dtheta}), 32'h14);
        rdy_mode = 0;
        tick();
        chk("stall_accept", 32'(slice_valid), 0);
        ticks(2);
`ifdef SLICE_SCHED_OVERRUN_CNT_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        chk("stall_count", 32'(overrun_count), 32'(exp_cnt));

        // early index lands on a pending slice
        wait_slice(10, 2000);
        rdy_mode = 2;
        gen_ph = 0;
        tick();
        chk("early_idx_ovr", 32'(overrun), 1);
        chk("early_idx_slice", 32'({slice_valid, dtheta}), 32'h10);
        rdy_mode = 0;

        // reset mid-run with the sensor held high
        sync_index(2000);
        rst_in = 1'b1;
        gen_on = 1'b0;
        ir_man = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("mrst_outputs",
            32'({slice_valid, dtheta, locked, overrun, overrun_count}), 0);
        ticks(20);
        ir_man = 1'b0;
        ticks(5);
        gen_len = 320;
        gen_ph = 0;
        gen_on = 1'b1;
        ticks(320);
        chk("mrst_no_false_idx", 32'(locked), 0);
        tick();
        chk("mrst_relock", 32'(locked), 1);

        // index stream stops: timeout back to idle
        gen_on = 1'b0;
        ir_man = 1'b0;
        ticks(65534);
        chk("tmo_before", 32'(locked), 1);
        tick();
        chk("tmo_unlocked", 32'({locked, slice_valid}), 0);
        gen_ph = 0;
        gen_on = 1'b1;
        ticks(320);
        chk("tmo_measure", 32'(locked), 0);
        tick();
        chk("tmo_relock", 32'(locked), 1);

        // 8-cycle period: interval clamps to one cycle
        gen_len = 8;
        gen_ph = 4;
        sync_index(20);
        ticks(8);
        chk("fast_slice0", 32'({slice_valid, dtheta}), 32'h10);
        gen_len = 40;
        ticks(15);
        chk("fast_theta15", 32'({slice_valid, dtheta}), 32'h1F);
        ticks(10);
        chk("fast_hold15", 32'({slice_valid, dtheta}), 32'h0F);
        ticks(15);
        chk("fast_next_idx", 32'({slice_valid, dtheta}), 32'h10);

        // random periods and random consumer stalls
        rdy_mode = 1;
        for (int r = 0; r < 6; r++) begin
            gen_len = int'($urandom_range(24, 600));
            sync_index(700);
        end
        ticks(gen_len);
        rdy_mode = 0;
        ticks(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/slice_scheduler.md
SLICE_SCHEDULER -- requirements
Module: slice_scheduler

Interface
REQ-001 SHALL have parameter ROTATIONAL_RES, default 1024: slices per rotation; must be a power of two.
REQ-002 SHALL have parameter PERIOD_W, default 24: width of the rotation-period counter in clk_in cycles.
REQ-003 SHALL have port clk_in, input, 1 bit: single clock; all logic on posedge.
REQ-004 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ir_tripped, input, 1 bit: debounced index level; a rising edge marks theta = 0.
REQ-006 SHALL have port slice_ready, input, 1 bit: display path accepts the current slice.
REQ-007 SHALL have port slice_valid, output, 1 bit: a slice request is pending.
REQ-008 SHALL have port dtheta, output, $clog2(ROTATIONAL_RES) bits: slice index of the pending or last request.
REQ-009 SHALL have port locked, output, 1 bit: rotation period is valid and slices are being scheduled.
REQ-010 SHALL have port overrun, output, 1 bit: one-cycle pulse when a slice is dropped.
REQ-011 SHALL have port overrun_count, output, 16 bits: saturating count of dropped slices (see Configuration).

Function
REQ-012 SHALL register ir_tripped once and detect a rising edge as (current & ~previous); the edge is "index" in the cycle it is detected.
REQ-013 SHALL implement FSM states IDLE, MEASURE and RUN.
- IDLE -> MEASURE on index.
- MEASURE -> RUN on the next index.
- RUN -> RUN on every index.
REQ-014 SHALL count clk_in cycles since the last index in a PERIOD_W-bit counter, cleared to 1 on index.
- On index in MEASURE or RUN, period is latched as the count value.
- slice interval = period >> $clog2(ROTATIONAL_RES), clamped to a minimum of 1.
REQ-015 SHALL, when the period counter reaches all-ones in MEASURE or RUN, go to IDLE in the next cycle, clear locked and clear slice_valid.
REQ-016 SHALL, on index in RUN or on the MEASURE->RUN transition, set dtheta = 0, set slice_valid = 1 in the following cycle, and restart the interval counter.
REQ-017 SHALL, in RUN, raise slice_valid with dtheta + 1 each time the interval counter reaches the interval.
REQ-018 SHALL hold dtheta at ROTATIONAL_RES-1 without wrapping until the next index; no further slices are scheduled in that rotation.
REQ-019 SHALL follow valid/ready handshake rules.
- slice_valid stays high, and dtheta stays stable, until a cycle with slice_valid & slice_ready.
- slice_valid deasserts in the cycle after acceptance unless a new slice is due in that same cycle.
REQ-020 SHALL, when a new slice comes due while slice_valid is high and unaccepted:
- pulse overrun for one cycle;
- advance dtheta;
- keep slice_valid high.
REQ-021 SHALL resolve simultaneous index and interval tick in favour of index.
REQ-022 SHALL resolve simultaneous index and pending unaccepted slice as index with an overrun pulse.
REQ-023 SHALL assert locked only in RUN.

Reset
REQ-024 SHALL, on rst_in = 1 at a clock edge (including mid-rotation), next cycle have:
- state IDLE;
- slice_valid = 0, dtheta = 0, locked = 0, overrun = 0;
- period, interval and edge registers = 0;
- overrun_count = 0.
REQ-025 SHALL treat ir_tripped held high through reset release as not an index.

Configuration
REQ-026 SHALL, with SLICE_SCHED_OVERRUN_CNT_EN defined, increment overrun_count on each overrun pulse, saturating at 16'hFFFF.
REQ-027 SHALL, without SLICE_SCHED_OVERRUN_CNT_EN, keep the overrun_count port and tie it to 0; overrun still pulses.

Structure
REQ-028 SHALL take ROTATIONAL_RES default, the theta_t typedef and the sched_state_t enum from shared package display_pkg.
REQ-029 SHALL place edge detection, period counting, the period latch and timeout in one sub-module, period_meter.
- period_meter outputs: index, period, period_valid, timeout.
- The FSM, interval counter and handshake stay in slice_scheduler.

Verification
Bench parameters: ROTATIONAL_RES=16, PERIOD_W=16.
REQ-030 SHALL cover: index edges every 1600 cycles, slice_ready=1 -> locked=1 one cycle after the 2nd index; slice_valid pulses every 100 cycles with dtheta 0..15; no overrun.
REQ-031 SHALL cover: steady 1600-cycle rotation, slice_ready=0 for 150 cycles at dtheta=3 -> one overrun pulse; dtheta=4 held until ready; overrun_count=1 with macro, 0 without.
REQ-032 SHALL cover: index edges stop after lock -> 65535 cycles later locked=0, slice_valid=0, state IDLE; the next two indices relock.
REQ-033 SHALL cover: period 8 cycles (< ROTATIONAL_RES) -> interval clamped to 1; dtheta reaches 15 and holds until the next index.
REQ-034 SHALL cover: rotation speeds up so index arrives at dtheta=10 with slice pending -> overrun pulse; dtheta=0, slice_valid=1 next cycle.
REQ-035 SHALL cover: rst_in asserted for one cycle mid-RUN with ir_tripped high -> all outputs 0 next cycle; no index until ir_tripped falls and rises again.
